// File: rtl/req_rr_arbiter.sv
// ---------------------------------------------------------------------------
// req_rr_arbiter
//   Upstream stage of the 8-to-3 one-hot encoder. Sticky request pulses from
//   eight sources are collected in a pending vector. A round-robin search
//   picks one pending source and presents it as a registered one-hot grant.
//   The grant is held until the consumer acknowledges it.
//
// Ports
//   clk         : system clock; all state changes on the rising edge
//   rst         : asynchronous, active-high reset
//   req[N-1:0]  : request pulses, one bit per source
//   ack         : consumer took the current grant (used only while grant_valid)
//   grant       : registered one-hot grant, all-zero when grant_valid=0
//   grant_valid : high while grant holds a live one-hot value
//   pending     : registered sticky pending-request vector
//   miss_cnt    : saturating count of cycles with at least one collided request
// ---------------------------------------------------------------------------
module req_rr_arbiter #(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             ack,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [N-1:0]     pending,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [N-1:0]       r_pending;
  logic [N-1:0]       w_pending_next;
  logic [N-1:0]       r_grant;
  logic [N-1:0]       w_grant_next;
  logic               r_grant_valid;
  logic               w_grant_valid_next;
  logic [2:0]         r_gnt_idx;
  logic [2:0]         w_gnt_idx_next;
  logic [2:0]         r_ptr;
  logic [2:0]         w_ptr_next;
  logic [CNT_W-1:0]   r_miss_cnt;

  logic [N-1:0]       w_clr;
  logic [N-1:0]       w_collide_bits;
  logic               w_collide;
  logic               w_found;
  logic [2:0]         w_win_idx;
  logic [2:0]         w_cand;

  // Only a live, acknowledged grant clears its pending bit.
  assign w_clr = (ack && r_grant_valid) ? r_grant : '0;

  // A request arriving on the bit being cleared survives (req ORed last).
  assign w_pending_next = (r_pending & ~w_clr) | req;

  // A collision is a request on a bit that is already pending and not being
  // cleared this edge: that pulse carries no new information and is lost.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_collide
      assign w_collide_bits[gi] = req[gi] & r_pending[gi] & ~w_clr[gi];
    end
  endgenerate

  assign w_collide = |w_collide_bits;

  // Round-robin search over the registered pending vector, starting one past
  // the last granted index. k=8 wraps back to ptr itself, so a lone request
  // on the previously granted bit is still found.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_cand    = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = r_ptr + 3'(k);
      if (!w_found && r_pending[w_cand]) begin
        w_found   = 1'b1;
        w_win_idx = w_cand;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_next       = r_state;
    w_grant_next       = r_grant;
    w_grant_valid_next = r_grant_valid;
    w_gnt_idx_next     = r_gnt_idx;
    w_ptr_next         = r_ptr;
    case (r_state)
      IDLE: begin
        w_grant_next       = '0;
        w_grant_valid_next = 1'b0;
        if (w_found) begin
          w_grant_next       = N'(1) << w_win_idx;
          w_grant_valid_next = 1'b1;
          w_gnt_idx_next     = w_win_idx;
          w_state_next       = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          w_ptr_next         = r_gnt_idx;
          w_grant_next       = '0;
          w_grant_valid_next = 1'b0;
          w_state_next       = IDLE;
        end
      end
      default: begin
        w_state_next       = IDLE;
        w_grant_next       = '0;
        w_grant_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pending     <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_gnt_idx     <= '0;
      r_ptr         <= 3'd7;
      r_miss_cnt    <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pending     <= w_pending_next;
      r_grant       <= w_grant_next;
      r_grant_valid <= w_grant_valid_next;
      r_gnt_idx     <= w_gnt_idx_next;
      r_ptr         <= w_ptr_next;
      // Saturate rather than wrap.
      if (w_collide && (r_miss_cnt != {CNT_W{1'b1}})) begin
        r_miss_cnt <= r_miss_cnt + 1'b1;
      end
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign pending     = r_pending;
  assign miss_cnt    = r_miss_cnt;

endmodule

// File: tb/tb_req_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_req_rr_arbiter
//   Self-checking bench for req_rr_arbiter. A reference model tracks the
//   arbiter as a set of pending sources, the index currently granted (-1 when
//   none), the last served index and a miss counter, and is stepped once per
//   clock edge alongside the design.
// ---------------------------------------------------------------------------
module tb_req_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       ack;
  logic [7:0] grant;
  logic       grant_valid;
  logic [7:0] pending;
  logic [7:0] miss_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit m_pend [8];
  int m_gidx;
  int m_last;
  int m_miss;

  req_rr_arbiter #(.N(8), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .ack         (ack),
    .grant       (grant),
    .grant_valid (grant_valid),
    .pending     (pending),
    .miss_cnt    (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
    m_gidx = -1;
    m_last = 7;
    m_miss = 0;
  endfunction

  function automatic logic [7:0] m_grant_vec();
    logic [7:0] v;
    v = 8'h00;
    if (m_gidx >= 0) v[m_gidx] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] m_pend_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // One clock edge of the arbiter, stated from its rules.
  function automatic void m_step(input logic [7:0] r, input logic a);
    bit old_pend [8];
    int served;
    bit lost;
    for (int i = 0; i < 8; i++) old_pend[i] = m_pend[i];
    served = (a && m_gidx >= 0) ? m_gidx : -1;
    lost = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (r[i] && old_pend[i] && i != served) lost = 1'b1;
      m_pend[i] = (old_pend[i] && i != served) || r[i];
    end
    if (m_gidx >= 0) begin
      if (a) begin
        m_last = m_gidx;
        m_gidx = -1;
      end
    end else begin
      for (int k = 1; k <= 8; k++) begin
        if (m_gidx < 0 && old_pend[(m_last + k) % 8]) m_gidx = (m_last + k) % 8;
      end
    end
    if (lost && m_miss < 255) m_miss = m_miss + 1;
  endfunction

  task automatic cycle(input logic [7:0] r, input logic a);
    req = r;
    ack = a;
    @(posedge clk);
    m_step(r, a);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    m_reset();
    req = 8'h00;
    ack = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (grant !== 8'h00 || grant_valid !== 1'b0 || pending !== 8'h00 || miss_cnt !== 8'h00) begin
      bad++;
      $display("FAIL reset_init: grant=%h gv=%b pend=%h miss=%0d, need all zero", grant, grant_valid, pending, miss_cnt);
    end
    cycle(8'h10, 1'b0);
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);
    total++;
    if (grant !== 8'h10 || grant_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_grant: grant=%h gv=%b, need 10/1", grant, grant_valid);
    end
    // Assert reset between edges; outputs must clear without a clock edge.
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    total++;
    if (grant !== 8'h00 || grant_valid !== 1'b0 || pending !== 8'h00 || miss_cnt !== 8'h00) begin
      bad++;
      $display("FAIL reset_async: grant=%h gv=%b pend=%h miss=%0d, need all zero", grant, grant_valid, pending, miss_cnt);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle(8'h00, 1'b0);
      total++;
      if (grant !== 8'h00 || grant_valid !== 1'b0 || pending !== 8'h00) begin
        bad++;
        $display("FAIL reset_quiet: cyc=%0d grant=%h gv=%b pend=%h, need zero", c, grant, grant_valid, pending);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    cycle(8'h04, 1'b0);
    total++;
    if (pending !== 8'h04 || grant_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_pend: pend=%h gv=%b, need 04/0", pending, grant_valid);
    end
    cycle(8'h00, 1'b0);
    total++;
    if (grant !== 8'h04 || grant_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: grant=%h gv=%b, need 04/1", grant, grant_valid);
    end
    for (int c = 0; c < 5; c++) begin
      cycle(8'h00, 1'b0);
      total++;
      if (grant !== 8'h04 || grant_valid !== 1'b1) begin
        bad++;
        $display("FAIL single_hold: cyc=%0d grant=%h gv=%b, need 04/1", c, grant, grant_valid);
      end
    end
    cycle(8'h00, 1'b1);
    total++;
    if (grant !== 8'h00 || grant_valid !== 1'b0 || pending !== 8'h00) begin
      bad++;
      $display("FAIL single_ack: grant=%h gv=%b pend=%h, need 00/0/00", grant, grant_valid, pending);
    end
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    logic [7:0] order [4];
    int waited;
    order[0] = 8'h01; order[1] = 8'h04; order[2] = 8'h20; order[3] = 8'h80;
    do_reset();
    cycle(8'hA5, 1'b0);
    for (int g = 0; g < 4; g++) begin
      waited = 0;
      cycle(8'h00, 1'b0);
      while (grant_valid !== 1'b1 && waited < 4) begin
        cycle(8'h00, 1'b0);
        waited++;
      end
      total++;
      if (grant !== order[g] || grant_valid !== 1'b1) begin
        bad++;
        $display("FAIL rr_order: idx=%0d grant=%h gv=%b, need %h/1", g, grant, grant_valid, order[g]);
      end
      cycle(8'h00, 1'b1);
    end
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);
    total++;
    if (grant_valid !== 1'b0 || pending !== 8'h00) begin
      bad++;
      $display("FAIL rr_drained: gv=%b pend=%h, need 0/00", grant_valid, pending);
    end
    $display("test_round_robin done");
  endtask

  task automatic test_ptr_rotation();
    cycle(8'h20, 1'b0);
    cycle(8'h00, 1'b0);
    total++;
    if (grant !== 8'h20) begin
      bad++;
      $display("FAIL rot_first: grant=%h, need 20", grant);
    end
    cycle(8'h00, 1'b1);
    cycle(8'h44, 1'b0);
    cycle(8'h00, 1'b0);
    total++;
    if (grant !== 8'h40 || grant_valid !== 1'b1) begin
      bad++;
      $display("FAIL rot_bit6: grant=%h gv=%b, need 40/1", grant, grant_valid);
    end
    cycle(8'h00, 1'b1);
    total++;
    if (grant_valid !== 1'b0 || pending !== 8'h04) begin
      bad++;
      $display("FAIL rot_gap: gv=%b pend=%h, need 0/04", grant_valid, pending);
    end
    cycle(8'h00, 1'b0);
    total++;
    if (grant !== 8'h04 || grant_valid !== 1'b1) begin
      bad++;
      $display("FAIL rot_bit2: grant=%h gv=%b, need 04/1", grant, grant_valid);
    end
    cycle(8'h00, 1'b1);
    $display("test_ptr_rotation done");
  endtask

  task automatic test_ack_same_bit();
    int miss_before;
    cycle(8'h02, 1'b0);
    cycle(8'h00, 1'b0);
    total++;
    if (grant !== 8'h02) begin
      bad++;
      $display("FAIL same_grant: grant=%h, need 02", grant);
    end
    miss_before = m_miss;
    cycle(8'h02, 1'b1);
    total++;
    if (pending[1] !== 1'b1 || grant_valid !== 1'b0 || int'(miss_cnt) != miss_before) begin
      bad++;
      $display("FAIL same_ack: pend=%h gv=%b miss=%0d, need bit1=1 gv=0 miss=%0d", pending, grant_valid, miss_cnt, miss_before);
    end
    cycle(8'h00, 1'b0);
    total++;
    if (grant !== 8'h02 || grant_valid !== 1'b1) begin
      bad++;
      $display("FAIL same_regrant: grant=%h gv=%b, need 02/1", grant, grant_valid);
    end
    cycle(8'h00, 1'b1);
    $display("test_ack_same_bit done");
  endtask

  task automatic test_saturation();
    int stray;
    do_reset();
    cycle(8'h01, 1'b0);
    cycle(8'h00, 1'b0);
    stray = 0;
    for (int c = 0; c < 300; c++) begin
      cycle(8'h03, 1'b0);
      if (grant !== 8'h01 || grant_valid !== 1'b1) stray++;
      if (c == 10) begin
        total++;
        if (int'(miss_cnt) != m_miss) begin
          bad++;
          $display("FAIL sat_early: miss=%0d, need %0d", miss_cnt, m_miss);
        end
      end
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL sat_grant_hold: %0d cycles with grant not 01", stray);
    end
    total++;
    if (miss_cnt !== 8'd255) begin
      bad++;
      $display("FAIL sat_value: miss=%0d, need 255", miss_cnt);
    end
    cycle(8'h03, 1'b0);
    total++;
    if (miss_cnt !== 8'd255) begin
      bad++;
      $display("FAIL sat_nowrap: miss=%0d, need 255", miss_cnt);
    end
    $display("test_saturation done");
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic a;
    int errs;
    do_reset();
    errs = 0;
    for (int c = 0; c < 600; c++) begin
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      a = ($urandom_range(0, 2) == 0);
      cycle(r, a);
      total++;
      if (grant !== m_grant_vec() || grant_valid !== (m_gidx >= 0) ||
          pending !== m_pend_vec() || int'(miss_cnt) != m_miss) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL rand: cyc=%0d grant=%h gv=%b pend=%h miss=%0d, need %h/%b/%h/%0d",
                   c, grant, grant_valid, pending, miss_cnt,
                   m_grant_vec(), (m_gidx >= 0), m_pend_vec(), m_miss);
      end
      total++;
      if ((grant & (grant - 8'h01)) !== 8'h00 || grant_valid !== (|grant)) begin
        bad++;
        $display("FAIL rand_onehot: cyc=%0d grant=%h gv=%b", c, grant, grant_valid);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b1;
    req = 8'h00;
    ack = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_ptr_rotation();
    test_ack_same_bit();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/req_rr_arbiter.md
Name: req_rr_arbiter

Overview:
- Upstream stage of the 8-to-3 one-hot encoder.
- Latches sticky request pulses from 8 sources and arbitrates among pending sources round-robin.
- Presents a registered, strictly one-hot (or all-zero) grant vector that the encoder converts to an index plus valid.
- Grant is held stable until the consumer acknowledges it.

Parameters:
- N, 8, number of request sources and width of grant vector; only 8 is supported.
- CNT_W, 8, width of saturating collision counter.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request pulses; bit i high for one or more cycles requests service for source i.
- ack  input  1  consumer has taken the current grant; meaningful only while grant_valid=1.
- grant  output  8  registered one-hot grant; all-zero when grant_valid=0.
- grant_valid  output  1  high while grant holds a live one-hot value.
- pending  output  8  registered sticky pending-request vector.
- miss_cnt  output  CNT_W  saturating count of cycles with at least one collided request.

Behaviour:
- Reset (async, on rst high, independent of clk):
  - pending=0, grant=0, grant_valid=0, miss_cnt=0.
  - Round-robin pointer ptr=7, so the first search starts at bit 0.
  - FSM=IDLE.
- Pending update, every edge:
  - pending_next = (pending & ~clr) | req.
  - clr is the one-hot grant when ack=1 and grant_valid=1, else 0.
  - When req[i] and clr[i] coincide, pending[i] stays 1 (the new request survives).
- Collision:
  - Bit i collides when req[i]=1, pending[i]=1 and clr[i]=0.
  - miss_cnt increments by 1 per edge with at least one collision, regardless of how many bits collide.
  - Saturates at 2^CNT_W-1; never wraps.
- FSM states: IDLE, GRANT.
  - IDLE, pending==0: stay; grant=0, grant_valid=0.
  - IDLE, pending!=0: search indices ptr+1, ptr+2, ... modulo 8; the first set pending bit wins.
    - Register grant=one-hot(winner), grant_valid=1, go to GRANT.
    - The search uses the registered pending, not this cycle's req.
  - GRANT, ack=0: hold grant and grant_valid unchanged; new requests only accumulate in pending.
  - GRANT, ack=1:
    - Clear the granted pending bit, subject to the req override above.
    - ptr = granted index.
    - grant=0, grant_valid=0, go to IDLE.
- ack in IDLE is ignored: no state change, no clear.
- Latency and throughput:
  - req high in cycle c sets pending at edge c+1.
  - grant_valid rises at edge c+2 if the FSM is idle.
  - After an ack there is at least one IDLE cycle with grant_valid=0 before the next grant, so the maximum rate is one grant per 2 cycles.
- Invariants:
  - grant is always 0 or exactly one bit set.
  - grant_valid == |grant.
  - grant is never changed while grant_valid=1 and ack=0.
- Reset mid-GRANT: outputs are forced to reset values immediately; all pending requests are discarded.

Test Plan:
- Reset: assert rst mid-run with grant=8'h10 held → grant=0, grant_valid=0, pending=0, miss_cnt=0 before the next edge; after release with no req, outputs stay 0.
- Single request: pulse req=8'h04 one cycle at c → pending=8'h04 after c+1, grant=8'h04 and grant_valid=1 after c+2; hold ack=0 for 5 cycles → grant stable; ack=1 one cycle → grant=0, pending=0 next edge.
- Round robin: from reset pulse req=8'hA5 once; ack each grant one cycle after it appears → grant order 8'h01, 8'h04, 8'h20, 8'h80, then grant_valid=0.
- Pointer rotation: after granting bit 5, pend bits 2 and 6 together → grant 8'h40 first, then 8'h04.
- Ack with same-bit request: while grant=8'h02, drive ack=1 and req=8'h02 in the same cycle → pending[1] stays 1, miss_cnt unchanged, bit 1 is re-granted after one IDLE cycle.
- Collision saturation: hold grant on bit 0, keep req=8'h03 high with ack=0 for 300 cycles → miss_cnt reaches 255 and stays 255; grant remains 8'h01 throughout.
